// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART blocks: parity modes,
// transmitter state encoding and a width helper for counters.
package uart_pkg;

  localparam int PARITY_NONE = 32'sd0;
  localparam int PARITY_EVEN = 32'sd1;
  localparam int PARITY_ODD  = 32'sd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    for (int v = value - 32'sd1; v > 32'sd0; v = v >>> 1) begin
      r = r + 32'sd1;
    end
    return (r < 32'sd1) ? 32'sd1 : r;
  endfunction

endpackage

// File: rtl/uart_baud_en.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last clock of
// each serial bit. Shared between the UART transmitter and receiver.
module uart_baud_en
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] count_r;

  assign bit_end = (count_r == CNT_W'(CLKS_PER_BIT - 1));

  // Free-running bit timer, held at zero while cleared and wrapping at bit end.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (bit_end) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB-first, optional
// parity, 1 or 2 stop bits. All outputs are registered from the next state.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BIT_W = clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY_MODE < 0 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_err
    $error("uart_tx_param: illegal parameter combination");
  end

  tx_state_e          state_r, state_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic [BIT_W-1:0]   bit_idx_r, bit_idx_s;
  logic               stop_idx_r, stop_idx_s;
  logic               parity_r, parity_s;
  logic               done_s, txd_s;
  logic               txd_r, ready_r, busy_r, done_r;
  logic               bit_end;

  uart_baud_en #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state_r == ST_IDLE),
    .bit_end (bit_end)
  );

  // Next-state, datapath updates and the line level of the next state.
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    bit_idx_s  = bit_idx_r;
    stop_idx_s = stop_idx_r;
    parity_s   = parity_r;
    done_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tx_valid) begin
          state_s  = ST_START;
          shift_s  = tx_data;
          parity_s = (PARITY_MODE == PARITY_ODD) ? ~^tx_data : ^tx_data;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_s   = ST_DATA;
          bit_idx_s = '0;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_s = shift_r >> 1;
          if (bit_idx_r == BIT_W'(DATA_BITS - 1)) begin
            state_s    = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            stop_idx_s = 1'b0;
          end else begin
            bit_idx_s = bit_idx_r + 1'b1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_s    = ST_STOP;
          stop_idx_s = 1'b0;
        end else begin
          state_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_idx_r == 1'(STOP_BITS - 1)) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end else begin
            stop_idx_s = stop_idx_r + 1'b1;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    case (state_s)
      ST_START:  txd_s = 1'b0;
      ST_DATA:   txd_s = shift_s[0];
      ST_PARITY: txd_s = parity_s;
      default:   txd_s = 1'b1;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      shift_r    <= '0;
      bit_idx_r  <= '0;
      stop_idx_r <= 1'b0;
      parity_r   <= 1'b0;
      txd_r      <= 1'b1;
      ready_r    <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      bit_idx_r  <= bit_idx_s;
      stop_idx_r <= stop_idx_s;
      parity_r   <= parity_s;
      txd_r      <= txd_s;
      ready_r    <= (state_s == ST_IDLE);
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= done_s;
    end
  end

  assign txd      = txd_r;
  assign tx_ready = ready_r;
  assign tx_busy  = busy_r;
  assign tx_done  = done_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four configurations (8N1, 8E1, 8O1,
// 5N2) checked cycle by cycle against a bit-list model of the frame.
module tb_uart_tx_param;

  logic       clock;
  logic       reset_n;
  logic [3:0] valid_v;
  logic [3:0] ready_v, txd_v, busy_v, done_v;
  logic [8:0] data_v [4];

  int cpb_t [4] = '{4, 4, 4, 2};
  int db_t  [4] = '{8, 8, 8, 5};
  int pm_t  [4] = '{0, 1, 2, 0};
  int sb_t  [4] = '{1, 1, 1, 2};

  int n_cmp = 0;
  int n_err = 0;
  bit exp_q [$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut_8n1 (
    .clock(clock), .reset_n(reset_n), .tx_data(data_v[0][7:0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .txd(txd_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut_8e1 (
    .clock(clock), .reset_n(reset_n), .tx_data(data_v[1][7:0]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .txd(txd_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) dut_8o1 (
    .clock(clock), .reset_n(reset_n), .tx_data(data_v[2][7:0]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .txd(txd_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

  uart_tx_param #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(2)) dut_5n2 (
    .clock(clock), .reset_n(reset_n), .tx_data(data_v[3][4:0]), .tx_valid(valid_v[3]),
    .tx_ready(ready_v[3]), .txd(txd_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame as a list of line levels: start, data LSB first, parity, stops.
  task automatic build_bits(input int k, input logic [8:0] word);
    int ones;
    ones = 0;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < db_t[k]; i++) begin
      exp_q.push_back(word[i]);
      ones += int'(word[i]);
    end
    if (pm_t[k] != 0) exp_q.push_back(((ones % 2) == 1) ^ (pm_t[k] == 2));
    for (int i = 0; i < sb_t[k]; i++) exp_q.push_back(1'b1);
  endtask

  task automatic start_word(input int k, input logic [8:0] word);
    @(negedge clock);
    check($sformatf("idle_ready[%0d]", k), ready_v[k], 1);
    check($sformatf("idle_txd[%0d]", k), txd_v[k], 1);
    check($sformatf("idle_done[%0d]", k), done_v[k], 0);
    data_v[k]  = word;
    valid_v[k] = 1'b1;
  endtask

  // Acceptance happens at the next rising edge; then every clock of the
  // frame is compared. Optional mid-frame valid pulse and reset abort.
  task automatic expect_frame(input int k, input logic [8:0] word, input bit drop,
                              input int pulse_at, input int abort_at);
    int  n;
    bit  aborted;
    build_bits(k, word);
    n = exp_q.size() * cpb_t[k];
    aborted = 1'b0;
    @(posedge clock);
    for (int i = 0; i < n && !aborted; i++) begin
      @(negedge clock);
      if (i == 0 && drop) valid_v[k] = 1'b0;
      if (i == pulse_at) begin
        data_v[k]  = 9'h033;
        valid_v[k] = 1'b1;
      end else if (i == pulse_at + 1) begin
        valid_v[k] = 1'b0;
      end
      if (i == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_txd", txd_v[k], 1);
        check("abort_ready", ready_v[k], 1);
        check("abort_busy", busy_v[k], 0);
        check("abort_done", done_v[k], 0);
        aborted = 1'b1;
      end else begin
        check($sformatf("txd[%0d] w=%0h clk%0d", k, word, i), txd_v[k], exp_q[i / cpb_t[k]]);
        check($sformatf("ready[%0d] clk%0d", k, i), ready_v[k], 0);
        check($sformatf("busy[%0d] clk%0d", k, i), busy_v[k], 1);
        check($sformatf("done[%0d] clk%0d", k, i), done_v[k], 0);
      end
    end
    if (!aborted) begin
      @(negedge clock);
      check($sformatf("end_done[%0d] w=%0h", k, word), done_v[k], 1);
      check($sformatf("end_ready[%0d]", k), ready_v[k], 1);
      check($sformatf("end_busy[%0d]", k), busy_v[k], 0);
      check($sformatf("end_txd[%0d]", k), txd_v[k], 1);
    end
  endtask

  initial begin
    logic [8:0] w;
    reset_n = 1'b0;
    valid_v = 4'b0000;
    for (int k = 0; k < 4; k++) data_v[k] = 9'h000;
    repeat (3) @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst_txd[%0d]", k), txd_v[k], 1);
      check($sformatf("rst_ready[%0d]", k), ready_v[k], 1);
      check($sformatf("rst_busy[%0d]", k), busy_v[k], 0);
      check($sformatf("rst_done[%0d]", k), done_v[k], 0);
    end
    @(negedge clock);
    reset_n = 1'b1;

    // 8N1 0xA5, even/odd parity on 0x07, 5N2 0x1F with upper bits set
    start_word(0, 9'h0A5); expect_frame(0, 9'h0A5, 1'b1, -10, -10);
    start_word(1, 9'h007); expect_frame(1, 9'h007, 1'b1, -10, -10);
    start_word(2, 9'h007); expect_frame(2, 9'h007, 1'b1, -10, -10);
    start_word(3, 9'h1FF); expect_frame(3, 9'h01F, 1'b1, -10, -10);

    // valid held: back-to-back frames with one idle-high clock between
    start_word(0, 9'h055); expect_frame(0, 9'h055, 1'b0, -10, -10);
    data_v[0] = 9'h0AA;
    expect_frame(0, 9'h0AA, 1'b1, -10, -10);

    // valid pulse mid-frame is ignored, and nothing follows the frame
    start_word(0, 9'h05A); expect_frame(0, 9'h05A, 1'b1, 9, -10);
    repeat (12) begin
      @(negedge clock);
      check("after_pulse_txd", txd_v[0], 1);
      check("after_pulse_ready", ready_v[0], 1);
      check("after_pulse_done", done_v[0], 0);
    end

    // reset during data bit 3, then a clean frame
    start_word(0, 9'h0C3); expect_frame(0, 9'h0C3, 1'b1, -10, 4 * 4 + 1);
    repeat (3) begin
      @(negedge clock);
      check("in_reset_txd", txd_v[0], 1);
      check("in_reset_done", done_v[0], 0);
    end
    reset_n = 1'b1;
    repeat (2) begin
      @(negedge clock);
      check("post_reset_txd", txd_v[0], 1);
      check("post_reset_done", done_v[0], 0);
    end
    start_word(0, 9'h03C); expect_frame(0, 9'h03C, 1'b1, -10, -10);

    // random words on every configuration
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        w = 9'($urandom_range(0, (1 << db_t[k]) - 1));
        start_word(k, w);
        expect_frame(k, w, 1'b1, -10, -10);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
